bcd_counter_display: RTL
========================

// Module: bcd_counter_display
// PURPOSE
// - 8-digit BCD up/down counter with prescaled count tick; encodes digits into 7-segment codes for the display scanner.
// - Drives the 64-bit `display` bus of the 8-digit scan controller: one active-low segment byte per digit.
// - Sits between user controls (switch/button levels) and the display scan stage in the counter-and-display design.
// PARAMETERS
// - TICK_DIV  10_000_000  clk cycles per count step (100 MHz -> 10 Hz); legal range >= 2
// - LZB       1           1 = blank leading zeros (digit 0 is never blanked); 0 = show all digits
// PORTS
// - clk       in   1   system clock
// - rst       in   1   reset, synchronous, active-high
// - en        in   1   count enable (level); prescaler runs and digits step only while high
// - dir       in   1   1 = count up, 0 = count down
// - clr       in   1   synchronous clear of digits and prescaler
// - load      in   1   single-cycle load strobe
// - load_val  in   32  BCD load value, nibble [31:28] = most significant digit
// - display   out  64  segment codes; [63:56] = MS digit (leftmost) ... [7:0] = LS digit
// - bcd       out  32  current BCD count, same nibble order as load_val
// - wrap      out  1   one-cycle pulse on 99999999->0 (up) or 0->99999999 (down)
// BEHAVIOUR
// - Clock: one clock. Reset: synchronous, active-high.
// - Reset: bcd=0, prescaler=0, wrap=0, display = digit 0 shows '0' (8'h03), other digits 8'hFF if LZB=1, else 8'h03.
// - Segment byte: bit7..bit1 = a,b,c,d,e,f,g; bit0 = dp. Active-low; dp is always 1.
// - Encoding: 0=03 1=9F 2=25 3=0D 4=99 5=49 6=41 7=1F 8=01 9=09 blank=FF.
// - Prescaler: counts 0..TICK_DIV-1 while en=1 and holds while en=0.
//   - step is asserted for exactly one cycle on terminal count; the prescaler then returns to 0.
// - Step up: LS digit +1. 9 rolls to 0 and carries to the next digit; the carry ripples combinationally in the same cycle.
// - Step down: LS digit -1. 0 rolls to 9 and borrows from the next digit.
// - All eight digits update in the same cycle as step.
// - wrap is high for the same cycle as the step that rolls all digits (up 99999999->00000000, down 00000000->99999999).
// - Priority per cycle: rst > clr > load > step.
//   - clr: bcd=0, prescaler=0, no wrap.
//   - load: bcd = load_val, prescaler=0, no wrap. A step in the same cycle is discarded.
// - load_val nibble >9 saturates to 9 for that digit (e.g. 32'h0000_00AF loads 00000099).
// - dir is sampled only on step cycles. Changing dir mid-prescale does not reset the prescaler.
// - Output latency:
//   - bcd changes on the edge after the step/load/clr cycle.
//   - display is registered from bcd, so it lags bcd by exactly 1 clk.
// - Leading-zero blanking (LZB=1): digit i is blanked iff it and every more-significant digit are 0; digit 0 is never blanked.
// - en=0 freezes bcd and the prescaler, but clr and load still act.
// STRUCTURE
// - Shared header seg_defs.vh:
//   - segment code constants SEG_0..SEG_9 and SEG_BLANK
//   - digit-count constant NDIG=8
// - Sub-module bcd_digit (one per digit, 8 instances): 4-bit register with inc/dec, carry/borrow in/out, sync clr/load with saturation.
// - Top level contains the prescaler, the carry chain, the blanking mask and the registered seg encoder (a function using seg_defs.vh).
// TESTING (simulate with TICK_DIV=4)
// - Reset: rst=1 for 2 clk -> bcd=0, wrap=0, display=64'hFFFF_FFFF_FFFF_FF03 (LZB=1).
// - Count up: en=1, dir=1 for 40 clk -> bcd=0x00000010, step every 4th clk.
//   - bcd 0x9 -> 0x10 on one step; display[15:0]=16'h9F03 one clk after bcd.
// - Up wrap: load 0x99999999, en=1, dir=1 -> next step gives bcd=0, wrap=1 for exactly 1 clk.
// - Down wrap: bcd=0, dir=0, en=1 -> next step gives bcd=0x99999999, wrap pulse, display all 8'h09.
// - Priority: clr=1 and load=1 in the same cycle as step -> bcd=0. Then load=1 with load_val=0x1234ABCD and a coincident step -> bcd=0x12349999 (saturated, no step applied).
// - Pause/blanking: en=0 for 20 clk -> bcd unchanged.
//   - bcd=0x00000105, LZB=1 -> display=64'hFFFF_FFFF_FF9F_0349; with LZB=0 -> upper five bytes = 8'h03.

Source files
------------

// File: rtl/bcd_counter_display_pkg.sv
// Shared definitions for the BCD counter / 7-segment display block.
// Contents:
//   NDIG              number of BCD digits driven by the counter
//   SEG_0..SEG_9      active-low segment bytes {a,b,c,d,e,f,g,dp}, dp off
//   SEG_BLANK         all segments off
//   seg_encode()      BCD nibble -> segment byte (non-decimal -> blank)
package bcd_counter_display_pkg;

  localparam int NDIG = 8;

  localparam logic [7:0] SEG_0     = 8'h03;
  localparam logic [7:0] SEG_1     = 8'h9F;
  localparam logic [7:0] SEG_2     = 8'h25;
  localparam logic [7:0] SEG_3     = 8'h0D;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h49;
  localparam logic [7:0] SEG_6     = 8'h41;
  localparam logic [7:0] SEG_7     = 8'h1F;
  localparam logic [7:0] SEG_8     = 8'h01;
  localparam logic [7:0] SEG_9     = 8'h09;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  function automatic logic [7:0] seg_encode(input logic [3:0] digit);
    logic [7:0] seg;
    case (digit)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One decade of the BCD counter.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   clr        synchronous clear to 0
//   load       synchronous load of load_val (nibbles above 9 saturate to 9)
//   load_val   4-bit load value
//   dir        1 = increment, 0 = decrement
//   cin        carry (up) / borrow (down) in; the digit steps when high
//   q          current digit value
//   cout       carry/borrow out: this digit steps and rolls over
module bcd_digit (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dir,
  input  logic       cin,
  output logic [3:0] q,
  output logic       cout
);

  logic [3:0] q_reg;

  assign q    = q_reg;
  // Combinational so the whole chain ripples within one cycle.
  assign cout = cin & (dir ? (q_reg == 4'd9) : (q_reg == 4'd0));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      q_reg <= 4'd0;
    end else if (load) begin
      q_reg <= (load_val > 4'd9) ? 4'd9 : load_val;
    end else if (cin) begin
      if (dir) begin
        q_reg <= (q_reg == 4'd9) ? 4'd0 : q_reg + 4'd1;
      end else begin
        q_reg <= (q_reg == 4'd0) ? 4'd9 : q_reg - 4'd1;
      end
    end
  end

endmodule

// File: rtl/bcd_counter_display.sv
// 8-digit BCD up/down counter with prescaled count tick and a registered
// 7-segment encoder feeding the display scan controller.
// Ports:
//   clk       system clock
//   rst       synchronous active-high reset
//   en        count enable (prescaler and digits advance only while high)
//   dir       1 = up, 0 = down (only matters on step cycles)
//   clr       synchronous clear of digits and prescaler
//   load      single-cycle load strobe of load_val
//   load_val  BCD load value, [31:28] = most significant digit
//   display   segment bytes, [63:56] = leftmost digit, one cycle behind bcd
//   bcd       current count
//   wrap      high during the step cycle that rolls every digit over
module bcd_counter_display
  import bcd_counter_display_pkg::*;
#(
  parameter int TICK_DIV = 10_000_000,
  parameter int LZB      = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                dir,
  input  logic                clr,
  input  logic                load,
  input  logic [4*NDIG-1:0]   load_val,
  output logic [8*NDIG-1:0]   display,
  output logic [4*NDIG-1:0]   bcd,
  output logic                wrap
);

  localparam int              PW       = $clog2(TICK_DIV);
  localparam logic [PW-1:0]   PRE_TC   = PW'(TICK_DIV - 1);
  localparam logic [8*NDIG-1:0] DISP_RST = (LZB != 0) ?
                                           {{(NDIG-1){SEG_BLANK}}, SEG_0} :
                                           {NDIG{SEG_0}};

  logic [PW-1:0]       pre_reg;
  logic                step;
  logic [NDIG:0]       carry;
  logic [8*NDIG-1:0]   display_reg;
  logic [8*NDIG-1:0]   display_next;

  // Prescaler: terminal count produces a one-cycle step.
  assign step = en & (pre_reg == PRE_TC);

  always_ff @(posedge clk) begin
    if (rst || clr || load) begin
      pre_reg <= '0;
    end else if (en) begin
      pre_reg <= step ? '0 : pre_reg + PW'(1);
    end
  end

  // Digit chain: a load or clear inside each digit overrides the step.
  assign carry[0] = step;

  generate
    for (genvar gi = 0; gi < NDIG; gi++) begin : g_digit
      bcd_digit u_digit (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .load     (load),
        .load_val (load_val[gi*4 +: 4]),
        .dir      (dir),
        .cin      (carry[gi]),
        .q        (bcd[gi*4 +: 4]),
        .cout     (carry[gi+1])
      );
    end
  endgenerate

  assign wrap = carry[NDIG] & ~clr & ~load & ~rst;

  // blank[i]: digit i and every digit above it are zero. Digit 0 is
  // always shown, so the mask only exists for digits 1..NDIG-1.
  logic [NDIG-1:1] blank;

  assign blank[NDIG-1] = (bcd[4*NDIG-1 -: 4] == 4'd0);

  generate
    for (genvar gi = 1; gi < NDIG - 1; gi++) begin : g_blank
      assign blank[gi] = (bcd[gi*4 +: 4] == 4'd0) & blank[gi+1];
    end

    for (genvar gi = 0; gi < NDIG; gi++) begin : g_seg
      if (gi == 0) begin : g_ls
        assign display_next[7:0] = seg_encode(bcd[3:0]);
      end else begin : g_upper
        assign display_next[gi*8 +: 8] = ((LZB != 0) && blank[gi]) ?
                                         SEG_BLANK : seg_encode(bcd[gi*4 +: 4]);
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      display_reg <= DISP_RST;
    end else begin
      display_reg <= display_next;
    end
  end

  assign display = display_reg;

endmodule
